// File: rtl/exec_pkg.sv
// exec_pkg: shared opcode, state and register/status index definitions for exec_unit
package exec_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SHL = 4'd5,
    OP_SHR = 4'd6,
    OP_SAR = 4'd7,
    OP_MUL = 4'd8,
    OP_CMP = 4'd9
  } op_t;
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_WB, S_FZ, S_FC, S_FN} state_t;
  localparam logic [1:0] SR_Z = 2'd1;
  localparam logic [1:0] SR_C = 2'd2;
  localparam logic [1:0] SR_N = 2'd3;
  localparam logic [4:0] R_ZERO = 5'd0;
  localparam logic [4:0] R_SR   = 5'd1;
  localparam logic [4:0] R_PC   = 5'd2;
endpackage

// File: rtl/exec_unit_mul_iter.sv
// mul_iter: iterative shift-add multiplier, final product presented combinationally with valid
module mul_iter #(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] lo,
  output logic        hi_nz,
  output logic        valid
);
  localparam int CW = $clog2(MUL_CYCLES + 1);
  logic [63:0] acc, mc, nxt;
  logic [31:0] mp;
  logic [CW-1:0] cnt;
  assign nxt   = acc + (mp[0] ? mc : 64'd0);
  assign lo    = nxt[31:0];
  assign hi_nz = |nxt[63:32];
  assign valid = cnt == CW'(1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      mc  <= {32'd0, a};
      mp  <= b;
      cnt <= CW'(MUL_CYCLES);
    end else if (cnt != '0) begin
      acc <= nxt;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute/writeback stage computing ALU/shift/multiply results and sequencing register and status writes
module exec_unit
  import exec_pkg::*;
#(
  parameter int MUL_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  dst,
  output logic [31:0] din,
  output logic [4:0]  csel,
  output logic        c_we,
  output logic        sr_in,
  output logic [1:0]  sr_sel,
  output logic        sr_we,
  output logic        busy,
  output logic        done
);
  state_t state;
  logic [4:0] rdst, sh;
  logic rfl, fc, alu_c, mhi, mvalid, accept;
  logic [32:0] add_w, shl_w, shr_w, sar_w;
  logic [31:0] alu_r, mlo;
  assign sh     = b[4:0];
  assign accept = start && state == S_IDLE;
  assign add_w  = {1'b0, a} + {1'b0, b};
  assign shl_w  = {1'b0, a} << sh;
  assign shr_w  = {a, 1'b0} >> sh;
  assign sar_w  = $signed({a, 1'b0}) >>> sh;
  always_comb begin
    alu_r = add_w[31:0];
    alu_c = 1'b0;
    case (op)
      OP_ADD: alu_c = add_w[32];
      OP_SUB, OP_CMP: begin
        alu_r = a - b;
        alu_c = a < b;
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_SHL: {alu_c, alu_r} = shl_w;
      OP_SHR: {alu_r, alu_c} = shr_w;
      OP_SAR: {alu_r, alu_c} = sar_w;
      default: ;
    endcase
  end
  mul_iter #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept && op == OP_MUL),
    .a     (a),
    .b     (b),
    .lo    (mlo),
    .hi_nz (mhi),
    .valid (mvalid)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      din    <= '0;
      csel   <= '0;
      c_we   <= 1'b0;
      sr_in  <= 1'b0;
      sr_sel <= SR_Z;
      sr_we  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      rdst   <= '0;
      rfl    <= 1'b0;
      fc     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          busy  <= 1'b1;
          rdst  <= dst;
          rfl   <= (op <= OP_CMP);
          state <= op == OP_MUL ? S_MULT : S_WB;
          c_we  <= op < OP_MUL && dst > R_PC;
          din   <= alu_r;
          csel  <= dst;
          fc    <= alu_c;
        end
        S_MULT: if (mvalid) begin
          state <= S_WB;
          c_we  <= rdst > R_PC;
          din   <= mlo;
          fc    <= mhi;
        end
        S_WB: begin
          state  <= S_FZ;
          c_we   <= 1'b0;
          sr_we  <= rfl;
          sr_sel <= SR_Z;
          sr_in  <= din == '0;
        end
        S_FZ: begin
          state  <= S_FC;
          sr_sel <= SR_C;
          sr_in  <= fc;
        end
        S_FC: begin
          state  <= S_FN;
          sr_sel <= SR_N;
          sr_in  <= din[31];
          done   <= 1'b1;
        end
        S_FN: begin
          state <= S_IDLE;
          sr_we <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: table-driven scoreboard bench for exec_unit with multi-cycle corner sequences
module tb_exec_unit;
  import exec_pkg::*;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] dst = '0;
  logic [31:0] din;
  logic [4:0] csel;
  logic c_we, sr_in, sr_we, busy, done;
  logic [1:0] sr_sel;
  exec_unit #(.MUL_CYCLES(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .dst    (dst),
    .din    (din),
    .csel   (csel),
    .c_we   (c_we),
    .sr_in  (sr_in),
    .sr_sel (sr_sel),
    .sr_we  (sr_we),
    .busy   (busy),
    .done   (done)
  );
  always #5 clk = ~clk;
  int cyc = 0, t_acc = 0, checks = 0, errors = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic        we;
    logic [31:0] din;
    logic [4:0]  csel;
    logic        fl;
    logic        z;
    logic        c;
    logic        n;
    int          base;
  } exp_t;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dst;
    exp_t        e;
  } vec_t;
  exp_t q[$];
  vec_t vt[19];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] d, input exp_t e);
    @(negedge clk);
    op = o; a = x; b = y; dst = d; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t_acc = cyc;
    q.push_back(e);
    op = 4'($urandom); a = $urandom; b = $urandom; dst = 5'($urandom);
  endtask
  task automatic wait_q(input int bud);
    for (int i = 0; i < bud && q.size() != 0; i++) @(posedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    q.delete();
  endtask
  logic gwe, gz, gc, gn;
  logic [31:0] gdin;
  logic [4:0] gcsel;
  int wl, zl, cl, nl, sr_cnt, lat;
  exp_t me;
  initial begin
    gwe = 0; gz = 0; gc = 0; gn = 0; gdin = 0; gcsel = 0; wl = 0; zl = 0; cl = 0; nl = 0; sr_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        gwe = 0; sr_cnt = 0;
      end else begin
        lat = cyc - t_acc + 1;
        if ((c_we || sr_we || done) && q.size() == 0) chk("stray", {29'd0, c_we, sr_we, done}, 32'd0);
        if (c_we) begin
          gwe = 1; gdin = din; gcsel = csel; wl = lat;
        end
        if (sr_we) begin
          sr_cnt++;
          case (sr_sel)
            2'd1: begin gz = sr_in; zl = lat; end
            2'd2: begin gc = sr_in; cl = lat; end
            2'd3: begin gn = sr_in; nl = lat; end
            default: chk("sr_sel", 32'(sr_sel), 32'd1);
          endcase
        end
        if (done && q.size() != 0) begin
          me = q.pop_front();
          chk("we", 32'(gwe), 32'(me.we));
          if (me.we) begin
            chk("din", gdin, me.din);
            chk("csel", 32'(gcsel), 32'(me.csel));
            chk("we_lat", 32'(wl), 32'(me.base + 1));
          end
          chk("sr_cnt", 32'(sr_cnt), me.fl ? 32'd3 : 32'd0);
          if (me.fl) begin
            chk("z", 32'(gz), 32'(me.z));
            chk("c", 32'(gc), 32'(me.c));
            chk("n", 32'(gn), 32'(me.n));
            chk("z_lat", 32'(zl), 32'(me.base + 2));
            chk("c_lat", 32'(cl), 32'(me.base + 3));
            chk("n_lat", 32'(nl), 32'(me.base + 4));
          end
          chk("done_lat", 32'(lat), 32'(me.base + 4));
          gwe = 0; sr_cnt = 0;
        end
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
  initial begin
    vt[0]  = '{OP_ADD, 32'hFFFFFFFF, 32'h1, 5'd5,  '{1'b1, 32'h0,        5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 0}};
    vt[1]  = '{OP_CMP, 32'h3,        32'h7, 5'd9,  '{1'b0, 32'hFFFFFFFC, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 0}};
    vt[2]  = '{OP_SAR, 32'h80000000, 32'h4, 5'd2,  '{1'b0, 32'hF8000000, 5'd2,  1'b1, 1'b0, 1'b0, 1'b1, 0}};
    vt[3]  = '{OP_SUB, 32'd10,       32'd3, 5'd6,  '{1'b1, 32'h7,        5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 0}};
    vt[4]  = '{OP_SUB, 32'd5,        32'd5, 5'd31, '{1'b1, 32'h0,        5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
    vt[5]  = '{OP_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, '{1'b1, 32'h00F000F0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 0}};
    vt[6]  = '{OP_OR,  32'h80000000, 32'h1, 5'd4,  '{1'b1, 32'h80000001, 5'd4,  1'b1, 1'b0, 1'b0, 1'b1, 0}};
    vt[7]  = '{OP_XOR, 32'h12345678, 32'h12345678, 5'd8, '{1'b1, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
    vt[8]  = '{OP_SHL, 32'h80000001, 32'h1, 5'd10, '{1'b1, 32'h2,        5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 0}};
    vt[9]  = '{OP_SHL, 32'h5,        32'h0, 5'd11, '{1'b1, 32'h5,        5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 0}};
    vt[10] = '{OP_SHR, 32'h3,        32'h1, 5'd12, '{1'b1, 32'h1,        5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 0}};
    vt[11] = '{OP_SHR, 32'h7,       32'h20, 5'd13, '{1'b1, 32'h7,        5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 0}};
    vt[12] = '{OP_SAR, 32'h80000000, 32'd31, 5'd14, '{1'b1, 32'hFFFFFFFF, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 0}};
    vt[13] = '{OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd15, '{1'b1, 32'h80000000, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1, 0}};
    vt[14] = '{OP_MUL, 32'd6,        32'd7, 5'd16, '{1'b1, 32'd42,       5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 32}};
    vt[15] = '{OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, '{1'b1, 32'h1, 5'd17, 1'b1, 1'b0, 1'b1, 1'b0, 32}};
    vt[16] = '{OP_ADD, 32'd4,        32'd5, 5'd1,  '{1'b0, 32'd9,        5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 0}};
    vt[17] = '{OP_ADD, 32'd0,        32'd0, 5'd0,  '{1'b0, 32'd0,        5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 0}};
    vt[18] = '{OP_SHL, 32'h40000000, 32'h2, 5'd18, '{1'b1, 32'h0,        5'd18, 1'b1, 1'b1, 1'b1, 1'b0, 0}};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", din, 32'd0);
    chk("rst_csel", 32'(csel), 32'd0);
    chk("rst_c_we", 32'(c_we), 32'd0);
    chk("rst_sr_in", 32'(sr_in), 32'd0);
    chk("rst_sr_sel", 32'(sr_sel), 32'd1);
    chk("rst_sr_we", 32'(sr_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 19; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, vt[i].dst, vt[i].e);
      wait_q(60);
    end
    issue(OP_MUL, 32'h10000, 32'h10000, 5'd7, '{1'b1, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32});
    repeat (9) @(posedge clk);
    op = OP_ADD; a = 32'd1; b = 32'd1; dst = 5'd3; start = 1'b1;
    chk("busy_mul", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_q(60);
    issue(OP_ADD, 32'd1, 32'd2, 5'd5, '{1'b1, 32'd3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    repeat (3) @(posedge clk);
    #1;
    chk("done_seen", 32'(done), 32'd1);
    op = OP_ADD; a = 32'd8; b = 32'd8; dst = 5'd6; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("busy_after_done_start", 32'(busy), 32'd0);
    wait_q(5);
    issue(4'd12, 32'd1, 32'd2, 5'd9, '{1'b0, 32'd0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 0});
    repeat (4) @(posedge clk);
    issue(OP_OR, 32'd1, 32'd2, 5'd9, '{1'b1, 32'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    wait_q(60);
    issue(OP_MUL, 32'd3, 32'd5, 5'd8, '{1'b1, 32'd15, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 32});
    repeat (19) @(posedge clk);
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_c_we", 32'(c_we), 32'd0);
    chk("mrst_sr_we", 32'(sr_we), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    chk("mrst_idle", 32'(busy), 32'd0);
    issue(OP_ADD, 32'd2, 32'd2, 5'd4, '{1'b1, 32'd4, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 0});
    wait_q(60);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Execute/writeback stage sitting directly downstream of the SRM register file. It consumes the two read-port values (`aout`/`bout`), computes an ALU, shift or iterative-multiply result, and then drives the register file's write port (`din`/`c_we`/`csel`). It also drives the status-bit write port (`sr_in`/`sr_we`/`sr_sel`) over a fixed multi-cycle sequence. A sequencer upstream issues one operation at a time and waits for `done`.

## Interface
Parameters:
- `MUL_CYCLES`, 32: iterations of the shift-add multiplier; must equal operand width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  issue strobe; accepted only when `busy`=0.
- `op`  in  4  operation code, captured on accept.
- `a`  in  32  operand A, from register-file `aout`, captured on accept.
- `b`  in  32  operand B, from register-file `bout`, captured on accept.
- `dst`  in  5  destination register index, captured on accept.
- `din`  out  32  write data to register file.
- `csel`  out  5  write index to register file.
- `c_we`  out  1  register write strobe, one cycle.
- `sr_in`  out  1  status bit value.
- `sr_sel`  out  2  status bit index (1=Z, 2=C, 3=N; never 0).
- `sr_we`  out  1  status write strobe.
- `busy`  out  1  high from the accept cycle +1 through the `done` cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Ops: 0 ADD, 1 SUB (a−b), 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR (logical), 7 SAR, 8 MUL (low 32 bits of the unsigned 64-bit product), 9 CMP (SUB without register write), 10–15 NOP.
- Shift amount is `b[4:0]`. All arithmetic is modulo 2^32.
- Flags:
  - Z = (result == 0). N = result[31].
  - C for ADD = carry out of bit 31.
  - C for SUB/CMP = 1 iff a < b unsigned (borrow).
  - C for shifts = last bit shifted out, or 0 when the shift amount is 0.
  - C for MUL = 1 iff the upper 32 product bits are nonzero.
  - C for logic ops = 0.
- FSM states: IDLE → (MUL only) MULT → WB → FZ → FC → FN → IDLE.
  - WB: `c_we`=1, `din`=result, `csel`=dst. `c_we` is suppressed for CMP, for NOP, and when dst ∈ {0,1,2}; the WB cycle is still spent, so latency stays uniform.
  - FZ/FC/FN: `sr_we`=1 with `sr_sel`=1/2/3 and `sr_in`=the matching flag. NOP writes no flags (`sr_we`=0) but still walks these states.
  - `done`=1 in FN.
- Status bit 0 is never written by this block. Write gating on status[0] is enforced by the register file, not here.
- `start` while `busy`=1 is ignored; no queueing.
- Operand and opcode captures are frozen for the whole operation, so upstream may change `a`, `b` and `op` freely after accept.

## Timing
- Reset values: `din`=0, `csel`=0, `c_we`=0, `sr_in`=0, `sr_sel`=1, `sr_we`=0, `busy`=0, `done`=0; state = IDLE.
- Accept at edge T when `start`=1 and state = IDLE.
- Non-MUL op: WB in cycle T+1, FZ T+2, FC T+3, FN/`done` T+4. `busy` is high T+1..T+4. Next accept is possible at T+5.
- MUL: MULT spans T+1..T+32, one multiplier bit per cycle. WB is T+33, flags T+34..T+36, `done` T+36.
- `start` asserted in the same cycle as `done` is ignored (`busy` is still 1).
- The register-file write lands on the WB edge. A dependent read of dst is valid from cycle T+2 onward.
- `rst` mid-operation: at the next edge the FSM returns to IDLE and all strobes drop. No partial `c_we`/`sr_we` follows, and no `done` is emitted.

## Structure
- Package `exec_pkg` holds:
  - `op_t` enum (4-bit).
  - `state_t` enum.
  - Flag-index constants `SR_Z`=1, `SR_C`=2, `SR_N`=3.
  - Reserved register indices `R_ZERO`=0, `R_SR`=1, `R_PC`=2.
- Sub-module `mul_iter`: iterative shift-add multiplier with a 64-bit accumulator.
  - Inputs: `start`, 32-bit `a` and `b`.
  - Outputs: `lo`, `hi_nz`, `valid`, with `valid` exactly `MUL_CYCLES` cycles after `start`.
- Combinational ALU/shifter and the FSM live in `exec_unit`.

## Test plan
- ADD a=0xFFFFFFFF, b=1, dst=5 → `c_we` at T+1 with `din`=0, `csel`=5; flags Z=1, C=1, N=0 at T+2..T+4; `done` at T+4.
- CMP a=3, b=7 → `c_we` never asserts; Z=0, C=1, N=1; `done` at T+4.
- SAR a=0x80000000, b=4, dst=2 → `c_we` stays low (reserved dst); N=1, C=0; `done` at T+4.
- MUL a=0x10000, b=0x10000, dst=7 → `din`=0 at T+33, C=1, Z=1; `done` at T+36. A `start` pulse at T+10 is ignored.
- `rst` asserted at T+20 of a MUL → no `c_we`/`sr_we`/`done` afterwards, and `busy`=0 from the following edge.
- NOP op=12 → no `c_we`, no `sr_we`; `done` at T+4; back-to-back accept at T+5 succeeds.
